// File: rtl/mem_stage_bus.sv
// Memory-access stage: byte-lane stores/loads to internal data memory, a stalling
// Req/Ack peripheral bus with timeout, address/bus exception codes, M/W register.
module mem_stage_bus #(
  parameter int          DM_WORDS   = 2048,
  parameter logic [31:0] DATA_START = 32'h0000_0000,
  parameter logic [31:0] DATA_END   = 32'h0000_2000,
  parameter logic [31:0] EXT_START  = 32'h0000_7F00,
  parameter logic [31:0] EXT_END    = 32'h0000_7F30,
  parameter int          PR_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Flush,
  input  logic        ValidM,
  input  logic [31:0] IRM,
  input  logic [31:0] PC4M,
  input  logic [31:0] AOM,
  input  logic [31:0] WDM,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        LoadSigned,
  output logic        Stall,
  output logic [29:0] PrAddr,
  output logic [31:0] PrWD,
  output logic [3:0]  PrBe,
  output logic        PrReq,
  output logic        PrWe,
  input  logic        PrAck,
  input  logic [31:0] PrRD,
  output logic        ValidW,
  output logic [31:0] IRW,
  output logic [31:0] PC4W,
  output logic [31:0] AOW,
  output logic [31:0] DRW,
  output logic [4:0]  ExcCodeW
);
  localparam int IDX_W = $clog2(DM_WORDS);
  localparam int CNT_W = $clog2(PR_TIMEOUT + 1);

  typedef enum logic [0:0] {IDLE, BUS} state_t;

  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   be_of = 4'b0001 << a;
      2'b01:   be_of = a[1] ? 4'b1100 : 4'b0011;
      default: be_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wd_of(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   wd_of = {4{d[7:0]}};
      2'b01:   wd_of = {2{d[15:0]}};
      default: wd_of = d;
    endcase
  endfunction

  function automatic logic [31:0] ext_of(input logic [1:0] sz, input logic sg,
                                         input logic [1:0] a, input logic [31:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(raw >> {a, 3'b000});
    h = a[1] ? raw[31:16] : raw[15:0];
    case (sz)
      2'b00:   ext_of = sg ? {{24{b[7]}}, b} : {24'b0, b};
      2'b01:   ext_of = sg ? {{16{h[15]}}, h} : {16'b0, h};
      default: ext_of = raw;
    endcase
  endfunction

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      abus_reg;
  logic [31:0]      wd_bus_reg;
  logic             we_bus_reg;
  logic [1:0]       size_bus_reg;
  logic             sgn_bus_reg;

  logic [31:0] dm [DM_WORDS];
  logic [31:0] dm_off, ext_off, dm_rd, wd_m, addr_sel, drw_next;
  logic [IDX_W-1:0] dm_idx;
  logic [3:0]  be_m;
  logic [4:0]  exc_next, exc_code;
  logic        dm_hit, ext_hit, is_mem, misalign, exc_addr, ext_go, timeout;
  logic        stall_int, dm_we, bus_sel;

  // Offset compares keep the window tests correct even when a window starts at 0.
  assign dm_off  = AOM - DATA_START;
  assign ext_off = AOM - EXT_START;
  assign dm_hit  = dm_off < (DATA_END - DATA_START);
  assign ext_hit = ext_off < (EXT_END - EXT_START);
  assign dm_idx  = IDX_W'(dm_off >> 2);
  assign dm_rd   = dm[dm_idx];
  assign be_m    = be_of(Size, AOM[1:0]);
  assign wd_m    = wd_of(Size, WDM);
  assign bus_sel = (state_reg == BUS);

  always_comb begin
    is_mem    = ValidM & (MemRead | MemWrite);
    misalign  = ((Size == 2'b01) & AOM[0]) | (Size[1] & (AOM[1:0] != 2'b00));
    exc_addr  = is_mem & (misalign | !(dm_hit | ext_hit));
    exc_code  = MemWrite ? 5'd5 : 5'd4;
    ext_go    = !bus_sel & is_mem & ext_hit & !exc_addr & !Flush;
    dm_we     = !bus_sel & is_mem & MemWrite & dm_hit & !exc_addr & !Flush;
    timeout   = (cnt_reg == CNT_W'(PR_TIMEOUT));
    stall_int = 1'b0;
    if (!Flush)
      stall_int = bus_sel ? (!PrAck & !timeout) : (ext_go & !PrAck);
    drw_next = 32'd0;
    exc_next = 5'd0;
    if (bus_sel) begin
      if (PrAck) begin
        if (!we_bus_reg)
          drw_next = ext_of(size_bus_reg, sgn_bus_reg, abus_reg[1:0], PrRD);
      end else if (timeout) begin
        exc_next = 5'd7;
      end
    end else if (exc_addr) begin
      exc_next = exc_code;
    end else if (is_mem & dm_hit & MemRead) begin
      drw_next = ext_of(Size, LoadSigned, AOM[1:0], dm_rd);
    end else if (ext_go & PrAck & MemRead) begin
      drw_next = ext_of(Size, LoadSigned, AOM[1:0], PrRD);
    end
  end

  // Reset_n gates the request so it drops the instant reset asserts.
  assign addr_sel = bus_sel ? abus_reg : AOM;
  assign PrAddr   = addr_sel[31:2];
  assign PrReq    = Reset_n & (bus_sel | ext_go);
  assign PrWe     = PrReq & (bus_sel ? we_bus_reg : MemWrite);
  assign PrBe     = bus_sel ? be_of(size_bus_reg, abus_reg[1:0]) : be_m;
  assign PrWD     = bus_sel ? wd_bus_reg : wd_m;
  assign Stall    = Reset_n & stall_int;

  always_ff @(posedge Clk) begin
    if (dm_we)
      for (int i = 0; i < 4; i++)
        if (be_m[i]) dm[dm_idx][8*i +: 8] <= wd_m[8*i +: 8];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      abus_reg     <= '0;
      wd_bus_reg   <= '0;
      we_bus_reg   <= 1'b0;
      size_bus_reg <= 2'b00;
      sgn_bus_reg  <= 1'b0;
      ValidW       <= 1'b0;
      IRW          <= '0;
      PC4W         <= '0;
      AOW          <= '0;
      DRW          <= '0;
      ExcCodeW     <= '0;
    end else begin
      if (Flush || stall_int) begin
        ValidW   <= 1'b0;
        IRW      <= '0;
        PC4W     <= '0;
        AOW      <= '0;
        DRW      <= '0;
        ExcCodeW <= '0;
      end else begin
        ValidW   <= ValidM;
        IRW      <= IRM;
        PC4W     <= PC4M;
        AOW      <= AOM;
        DRW      <= drw_next;
        ExcCodeW <= exc_next;
      end
      case (state_reg)
        IDLE: begin
          if (ext_go && !PrAck) begin
            state_reg    <= BUS;
            cnt_reg      <= CNT_W'(1);
            abus_reg     <= AOM;
            wd_bus_reg   <= wd_m;
            we_bus_reg   <= MemWrite;
            size_bus_reg <= Size;
            sgn_bus_reg  <= LoadSigned;
          end
        end
        default: begin
          if (Flush || PrAck || timeout) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_bus.sv
// Directed bench for mem_stage_bus: DM byte lanes, bus stall/ack, timeout,
// address exceptions, flush and asynchronous reset.
module tb_mem_stage_bus;
  logic        Clk, Reset_n, Flush, ValidM, MemRead, MemWrite, LoadSigned, PrAck;
  logic [31:0] IRM, PC4M, AOM, WDM, PrRD;
  logic [1:0]  Size;
  logic        Stall, PrReq, PrWe, ValidW;
  logic [29:0] PrAddr;
  logic [31:0] PrWD, IRW, PC4W, AOW, DRW;
  logic [3:0]  PrBe;
  logic [4:0]  ExcCodeW;
  int total = 0;
  int bad = 0;

  mem_stage_bus dut (
    .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush), .ValidM(ValidM), .IRM(IRM),
    .PC4M(PC4M), .AOM(AOM), .WDM(WDM), .MemRead(MemRead), .MemWrite(MemWrite),
    .Size(Size), .LoadSigned(LoadSigned), .Stall(Stall), .PrAddr(PrAddr),
    .PrWD(PrWD), .PrBe(PrBe), .PrReq(PrReq), .PrWe(PrWe), .PrAck(PrAck),
    .PrRD(PrRD), .ValidW(ValidW), .IRW(IRW), .PC4W(PC4W), .AOW(AOW),
    .DRW(DRW), .ExcCodeW(ExcCodeW)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic mid();
    @(negedge Clk);
  endtask

  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] d);
    ValidM = 1'b1; MemRead = rd; MemWrite = wr; Size = sz; LoadSigned = sg;
    AOM = a; WDM = d; IRM = 32'h8C00_0000 | a; PC4M = 32'h0040_0000 + a;
  endtask

  task automatic idle_in();
    ValidM = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Size = 2'b00; LoadSigned = 1'b0;
    AOM = '0; WDM = '0; IRM = '0; PC4M = '0;
  endtask

  // Single-cycle op: no stall, W shows valid result next edge.
  task automatic one(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                     input logic sg, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_drw, input logic [4:0] exp_exc);
    op(rd, wr, sz, sg, a, d);
    mid();
    chk({tag, ".stall"}, Stall, 0);
    chk({tag, ".req"}, PrReq, 0);
    cyc();
    chk({tag, ".validw"}, ValidW, 1);
    chk({tag, ".drw"}, DRW, exp_drw);
    chk({tag, ".exc"}, ExcCodeW, exp_exc);
  endtask

  initial begin
    Reset_n = 1'b1; Flush = 1'b0; PrAck = 1'b0; PrRD = '0;
    idle_in();
    #1 Reset_n = 1'b0;
    #1;
    chk("rst.validw", ValidW, 0);
    chk("rst.drw", DRW, 0);
    chk("rst.exc", ExcCodeW, 0);
    chk("rst.stall", Stall, 0);
    chk("rst.req", PrReq, 0);
    cyc(); cyc();
    Reset_n = 1'b1;
    cyc();

    // DM stores and loads with lane selection and extension
    op(0, 1, 2'b10, 0, 32'h10, 32'h1122_3344);
    mid();
    chk("sw.be", PrBe, 4'b1111);
    one("sw10", 0, 1, 2'b10, 0, 32'h10, 32'h1122_3344, 32'h0, 5'd0);
    chk("sw10.aow", AOW, 32'h10);
    chk("sw10.irw", IRW, 32'h8C00_0010);
    one("lb13", 1, 0, 2'b00, 1, 32'h13, 32'h0, 32'h0000_0011, 5'd0);
    one("lb10", 1, 0, 2'b00, 1, 32'h10, 32'h0, 32'h0000_0044, 5'd0);
    op(0, 1, 2'b01, 0, 32'h12, 32'h0000_80FF);
    mid();
    chk("sh.be", PrBe, 4'b1100);
    chk("sh.wd", PrWD, 32'h80FF_80FF);
    one("sh12", 0, 1, 2'b01, 0, 32'h12, 32'h0000_80FF, 32'h0, 5'd0);
    one("lh12s", 1, 0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFF_80FF, 5'd0);
    one("lh12u", 1, 0, 2'b01, 0, 32'h12, 32'h0, 32'h0000_80FF, 5'd0);
    one("lbu12", 1, 0, 2'b00, 0, 32'h12, 32'h0, 32'h0000_00FF, 5'd0);
    one("lb13s", 1, 0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFF_FF80, 5'd0);
    one("lw10", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h80FF_3344, 5'd0);
    op(0, 1, 2'b00, 0, 32'h11, 32'h0000_00AB);
    mid();
    chk("sb.be", PrBe, 4'b0010);
    chk("sb.wd", PrWD, 32'hABAB_ABAB);
    one("sw1ffc", 0, 1, 2'b10, 0, 32'h1FFC, 32'h5A5A_0001, 32'h0, 5'd0);
    one("lw1ffc", 1, 0, 2'b10, 0, 32'h1FFC, 32'h0, 32'h5A5A_0001, 5'd0);

    // Bus read: three wait cycles, then ack
    op(1, 0, 2'b10, 0, 32'h7F04, 32'h0);
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("busrd.stall", Stall, 1);
      chk("busrd.req", PrReq, 1);
      chk("busrd.we", PrWe, 0);
      chk("busrd.addr", {2'b00, PrAddr}, 32'h0000_1FC1);
      cyc();
      chk("busrd.bubble", ValidW, 0);
    end
    PrAck = 1'b1; PrRD = 32'hCAFE_BABE;
    mid();
    chk("busrd.ackstall", Stall, 0);
    chk("busrd.ackreq", PrReq, 1);
    cyc();
    chk("busrd.validw", ValidW, 1);
    chk("busrd.drw", DRW, 32'hCAFE_BABE);
    chk("busrd.exc", ExcCodeW, 0);
    PrAck = 1'b0; PrRD = '0;
    idle_in();
    mid();
    chk("busrd.reqdrop", PrReq, 0);
    cyc();

    // Bus write with no ack: timeout after 16 stalled cycles
    op(0, 1, 2'b10, 0, 32'h7F08, 32'h1234_5678);
    for (int i = 0; i < 16; i++) begin
      mid();
      chk("tmo.stall", Stall, 1);
      chk("tmo.req", PrReq, 1);
      chk("tmo.we", PrWe, 1);
      chk("tmo.wd", PrWD, 32'h1234_5678);
      cyc();
      chk("tmo.bubble", ValidW, 0);
    end
    mid();
    chk("tmo.laststall", Stall, 0);
    cyc();
    chk("tmo.exc", ExcCodeW, 7);
    chk("tmo.drw", DRW, 0);
    chk("tmo.validw", ValidW, 1);
    idle_in();
    mid();
    chk("tmo.reqdrop", PrReq, 0);
    cyc();

    // Address exceptions
    one("sw0", 0, 1, 2'b10, 0, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd0);
    one("lwmis", 1, 0, 2'b10, 0, 32'h2, 32'h0, 32'h0, 5'd4);
    one("shmis", 0, 1, 2'b01, 0, 32'h1, 32'h0000_FFFF, 32'h0, 5'd5);
    one("lw0", 1, 0, 2'b10, 0, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd0);
    one("lwunm", 1, 0, 2'b10, 0, 32'h5000, 32'h0, 32'h0, 5'd4);
    one("sbend", 0, 1, 2'b00, 0, 32'h2000, 32'h0, 32'h0, 5'd5);
    one("lwextend", 1, 0, 2'b10, 0, 32'h7F30, 32'h0, 32'h0, 5'd4);

    // Invalid op at a bad address: no access, no exception
    op(1, 0, 2'b10, 0, 32'h5000, 32'h0);
    ValidM = 1'b0;
    mid();
    chk("inv.stall", Stall, 0);
    cyc();
    chk("inv.validw", ValidW, 0);
    chk("inv.exc", ExcCodeW, 0);

    // Flush on a DM store leaves memory untouched
    op(0, 1, 2'b10, 0, 32'h10, 32'h5555_5555);
    Flush = 1'b1;
    cyc();
    chk("flst.validw", ValidW, 0);
    chk("flst.irw", IRW, 0);
    Flush = 1'b0;
    one("flst.lw", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h80FF_3344, 5'd0);

    // Flush in second cycle of a bus read; late ack ignored
    op(1, 0, 2'b10, 0, 32'h7F0C, 32'h0);
    cyc();
    Flush = 1'b1;
    mid();
    chk("flbus.req", PrReq, 1);
    cyc();
    chk("flbus.validw", ValidW, 0);
    Flush = 1'b0;
    idle_in();
    mid();
    chk("flbus.reqdrop", PrReq, 0);
    cyc();
    PrAck = 1'b1; PrRD = 32'h1234_5678;
    mid();
    chk("flbus.latestall", Stall, 0);
    cyc();
    chk("flbus.lateval", ValidW, 0);
    chk("flbus.latedrw", DRW, 0);
    PrAck = 1'b0; PrRD = '0;

    // Non-memory instruction passes through
    ValidM = 1'b1; IRM = 32'h0123_4567; PC4M = 32'h0000_0044; AOM = 32'h0000_9999;
    cyc();
    chk("alu.validw", ValidW, 1);
    chk("alu.irw", IRW, 32'h0123_4567);
    chk("alu.pc4w", PC4W, 32'h0000_0044);
    chk("alu.aow", AOW, 32'h0000_9999);
    chk("alu.drw", DRW, 0);
    chk("alu.exc", ExcCodeW, 0);

    // Reset asserted in the middle of a bus transaction
    op(1, 0, 2'b10, 0, 32'h7F10, 32'h0);
    cyc();
    #2 Reset_n = 1'b0;
    #1;
    chk("arst.req", PrReq, 0);
    chk("arst.stall", Stall, 0);
    chk("arst.validw", ValidW, 0);
    chk("arst.irw", IRW, 0);
    chk("arst.aow", AOW, 0);
    cyc();
    idle_in();
    Reset_n = 1'b1;
    mid();
    chk("arst.idle", PrReq, 0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage_bus.md
Name: mem_stage_bus

Overview:
- Parametrised next-generation memory-access (M) stage of the pipelined MIPS core, sitting between the E/M and M/W pipeline registers.
- Generates byte enables for sb/sh/sw, performs internal data-memory access, and performs sign/zero extension of load data.
- Adds a multi-cycle Req/Ack peripheral bus with stall and timeout, plus precise address and bus-error exception codes.
- Registers results into the W stage.

Parameters:
- DM_WORDS, 2048: internal data-memory depth in 32-bit words.
- DATA_START, 32'h0000_0000: first byte address of the DM window (inclusive).
- DATA_END, 32'h0000_2000: end of the DM window (exclusive); must be ≤ DATA_START+4*DM_WORDS.
- EXT_START, 32'h0000_7F00: first byte address of the peripheral window (inclusive).
- EXT_END, 32'h0000_7F30: end of the peripheral window (exclusive).
- PR_TIMEOUT, 16: number of cycles to wait for PrAck before raising a bus error; must be ≥ 2.

Ports:
- Clk  in  1  single clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Flush  in  1  exception flush: kill the current M-stage op and zero the W registers.
- ValidM  in  1  M stage holds a real instruction.
- IRM  in  32  instruction.
- PC4M  in  32  PC+4.
- AOM  in  32  effective address / ALU result.
- WDM  in  32  store data (already forwarded).
- MemRead  in  1  load op.
- MemWrite  in  1  store op.
- Size  in  2  access size: 00 = byte, 01 = half, 10 = word.
- LoadSigned  in  1  sign-extend load data.
- Stall  out  1  hold IF..M stages.
- PrAddr  out  30  peripheral word address, AOM[31:2].
- PrWD  out  32  lane-replicated store data.
- PrBe  out  4  byte enables.
- PrReq  out  1  bus request.
- PrWe  out  1  bus write.
- PrAck  in  1  bus acknowledge; PrRD is valid when high.
- PrRD  in  32  peripheral read data.
- ValidW  out  1  W-stage valid.
- IRW  out  32  W-stage instruction.
- PC4W  out  32  W-stage PC+4.
- AOW  out  32  W-stage address / ALU result.
- DRW  out  32  W-stage load data, extended.
- ExcCodeW  out  5  W-stage exception code; 0 = none.

Behaviour:
- Reset (async, Reset_n=0): all W outputs, PrReq, PrWe, Stall and the timeout counter go to 0; FSM goes to IDLE. DM contents are not cleared.
- Byte enables:
  - Byte: Be = 4'b0001 << AOM[1:0].
  - Half: Be = AOM[1] ? 1100 : 0011.
  - Word: Be = 1111.
- Store data: PrWD / DM data = WDM[7:0] replicated ×4 for byte, WDM[15:0] ×2 for half, WDM for word.
- Address check, combinational; applies only when ValidM and (MemRead|MemWrite):
  - Misaligned (half with A[0]=1, word with A[1:0]≠0) → code 4 for loads, 5 for stores.
  - Address outside both windows → same codes.
  - A faulting op issues no access and writes nothing.
- FSM states: IDLE, BUS.
  - IDLE, DM hit: write is committed at the rising edge when MemWrite & !Flush. Read is an async array read, lane-selected and extended into DRW at the same edge. Latency 1, no stall.
  - IDLE, EXT hit, no exception: assert PrReq (and PrWe for stores) combinationally, Stall = !PrAck. If PrAck is already high, complete this cycle and stay in IDLE; otherwise go to BUS with counter = 1.
  - BUS: PrReq, PrWe, PrAddr, PrBe and PrWD are held stable. Stall=1 until PrAck.
    - On PrAck: capture PrRD (lane-selected, extended) into DRW, load the W registers, return to IDLE; Stall=0 in the ack cycle.
    - When counter reaches PR_TIMEOUT with no ack: ExcCodeW = 7, DRW = 0, return to IDLE, Stall=0 in that cycle.
- While Stall=1, the W registers load a bubble each cycle (ValidW=0, all others 0).
- Non-stall edge: ValidW ← ValidM, and IRW/PC4W/AOW ← inputs.
- Load extension: byte lane = AOM[1:0], half lane = AOM[1]. Result is sign-extended if LoadSigned, else zero-extended. Word loads pass through unchanged.
- Flush takes priority over everything:
  - W registers are zeroed at the next edge.
  - The DM write is suppressed.
  - A BUS transaction is abandoned: FSM → IDLE, PrReq drops next cycle, and a late PrAck is ignored.
- A non-memory instruction passes straight through with DRW = 0 and ExcCodeW = 0.
- An invalid op (ValidM=0) produces no access and no exception.
- Reset asserted mid-BUS: PrReq drops immediately (async).

Test Plan:
- sw 0x11223344 to 0x10, then lb signed at 0x13 → DRW=0x00000011; lb at 0x10 → 0x00000044; sh 0x80FF at 0x12, then lh signed 0x12 → 0xFFFF80FF. Each op completes in 1 cycle with Stall=0.
- lw at 0x7F04, PrAck held low 3 cycles then high with PrRD=0xCAFEBABE → Stall high exactly 3 cycles, PrReq stable, ValidW=0 during the stall, then ValidW=1, DRW=0xCAFEBABE.
- sw to 0x7F08, PrAck never asserts → after PR_TIMEOUT=16 cycles ExcCodeW=7, Stall falls, PrReq deasserts the next cycle.
- lw at 0x0002 → ExcCodeW=4, no DM read; sh at 0x0001 → ExcCodeW=5 and a later DM readback shows the word unchanged; lw at 0x5000 (unmapped) → ExcCodeW=4.
- Flush asserted on the edge of a DM store → memory unchanged; Flush asserted in cycle 2 of a BUS read → PrReq low next cycle, a PrAck arriving afterwards causes no W update.
- Reset_n pulled low mid-BUS → PrReq, Stall and all W outputs go to 0 immediately, without waiting for a clock edge.
